// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one i2c_master among NREQ requesters.
// Latches the winner's command, sequences enable/ready and bounds each phase with a timeout.
module i2c_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0]   req_rw,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic [6:0]        m_addr,
    output logic              m_rw,
    output logic [7:0]        m_wdata,
    output logic              m_enable,
    input  logic [7:0]        m_rdata,
    input  logic              m_ready,
    output logic [1:0]        dbg_state
);

    // Requester handshake: req is a level request whose payload is sampled only on the
    // edge that raises gnt; gnt then stays high until the single-cycle done pulse, after
    // which the requester may drop req or keep it high to queue another transaction.

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   cur;
    logic [TW-1:0]   timer;
    logic [IW-1:0]   ptr_adv;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] win_onehot;
    logic [6:0]      win_addr;
    logic            win_rw;
    logic [7:0]      win_wdata;

    assign dbg_state = state;
    assign ptr_adv   = (cur == IW'(NREQ - 1)) ? '0 : cur + IW'(1);

    // Two descending passes: indices below ptr first, then indices at/after ptr override,
    // so the lowest set index at or after ptr wins and the search wraps otherwise.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        win_addr   = '0;
        win_rw     = 1'b0;
        win_wdata  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (i < int'(ptr))) begin
                win_found  = 1'b1;
                win_idx    = IW'(i);
                win_onehot = '0;
                win_onehot[i] = 1'b1;
                win_addr   = req_addr[7*i +: 7];
                win_rw     = req_rw[i];
                win_wdata  = req_wdata[8*i +: 8];
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                win_found  = 1'b1;
                win_idx    = IW'(i);
                win_onehot = '0;
                win_onehot[i] = 1'b1;
                win_addr   = req_addr[7*i +: 7];
                win_rw     = req_rw[i];
                win_wdata  = req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cur      <= '0;
            timer    <= '0;
            gnt      <= '0;
            done     <= '0;
            err      <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
            m_addr   <= '0;
            m_rw     <= 1'b0;
            m_wdata  <= '0;
            m_enable <= 1'b0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found && m_ready) begin
                        gnt      <= win_onehot;
                        cur      <= win_idx;
                        m_addr   <= win_addr;
                        m_rw     <= win_rw;
                        m_wdata  <= win_wdata;
                        m_enable <= 1'b1;
                        timer    <= '0;
                        busy     <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // Dropping enable as soon as the master leaves idle makes it STOP
                    // after this byte instead of chaining another one.
                    if (!m_ready) begin
                        m_enable <= 1'b0;
                        timer    <= '0;
                        state    <= BUSY;
                    end else if (timer == T_LAST) begin
                        m_enable <= 1'b0;
                        done     <= gnt;
                        err      <= 1'b1;
                        gnt      <= '0;
                        busy     <= 1'b0;
                        ptr      <= ptr_adv;
                        state    <= IDLE;
                    end else if (timer != '1) begin
                        timer <= timer + TW'(1);
                    end
                end
                BUSY: begin
                    if (m_ready) begin
                        done  <= gnt;
                        if (m_rw) begin
                            rdata <= m_rdata;
                        end
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= ptr_adv;
                        state <= IDLE;
                    end else if (timer == T_LAST) begin
                        done  <= gnt;
                        err   <= 1'b1;
                        gnt   <= '0;
                        ptr   <= ptr_adv;
                        state <= DRAIN;
                    end else if (timer != '1) begin
                        timer <= timer + TW'(1);
                    end
                end
                DRAIN: begin
                    // The master is still mid-transfer; wait for it before re-arbitrating.
                    if (m_ready) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Shares a single `i2c_master` among `NREQ` independent requesters, such as sensor pollers and config loaders. It arbitrates round-robin, latches the winner's command and sequences the master's `enable`/`ready` handshake. It returns read data and a per-requester completion pulse, and bounds every transaction with a timeout. It sits directly in front of `i2c_master`, and both blocks run on the same `clk`/`rst`.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 4095: maximum `clk` cycles allowed per handshake phase before abort.
- `clk`  in  1  system clock; the master's SCL divider also runs from it.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  per-requester transaction request, level.
- `req_addr`  in  7*NREQ  7-bit slave address per requester; slice i is bits [7i+6:7i].
- `req_rw`  in  NREQ  1 = read, 0 = write.
- `req_wdata`  in  8*NREQ  write byte per requester.
- `gnt`  out  NREQ  one-hot grant, held for the whole transaction.
- `done`  out  NREQ  one-cycle completion pulse to the granted requester.
- `err`  out  1  valid with `done`; 1 = transaction aborted by timeout.
- `rdata`  out  8  read byte; valid with `done` when the granted `rw` = 1.
- `busy`  out  1  arbiter is not in IDLE.
- `m_addr`  out  7  to master `addr`.
- `m_rw`  out  1  to master `rw`.
- `m_wdata`  out  8  to master `data_in`.
- `m_enable`  out  1  to master `enable`.
- `m_rdata`  in  8  from master `data_out`.
- `m_ready`  in  1  from master `ready`; high while the master is idle.

## Operation
- Reset values: `gnt`=0, `done`=0, `err`=0, `rdata`=0, `busy`=0, `m_addr`=0, `m_rw`=0, `m_wdata`=0, `m_enable`=0. The round-robin pointer resets to 0 and the state resets to IDLE.
- **IDLE:** if any `req` bit is set and `m_ready`=1, pick the winner. The search starts at pointer `ptr` and wraps modulo NREQ; the first set bit wins. On the same edge:
  - set `gnt[w]`;
  - latch `m_addr`/`m_rw`/`m_wdata` from slice w;
  - set `m_enable`=1 and clear the timer;
  - go to LAUNCH.
- **LAUNCH:** hold `m_enable`=1 until `m_ready` is sampled 0. Then drive `m_enable`=0, clear the timer and go to BUSY.
  - `m_enable` must drop as soon as the master leaves idle. This forces the master to issue STOP after the write ACK instead of chaining.
  - If the timer reaches TIMEOUT first: drop `m_enable`, pulse `done[w]` with `err`=1, go to IDLE.
- **BUSY:** wait for `m_ready`=1. On that edge:
  - pulse `done[w]` with `err`=0;
  - if `m_rw`=1, capture `rdata` from `m_rdata`; otherwise leave `rdata` unchanged;
  - clear `gnt`, set `ptr` = (w+1) mod NREQ, go to IDLE.
  - If the timer reaches TIMEOUT first: pulse `done[w]` with `err`=1 and go to DRAIN.
- **DRAIN:** `gnt`=0, `busy`=1, no arbitration. Go to IDLE when `m_ready`=1.
- The timer is a saturating counter of width clog2(TIMEOUT+1).
- Requester payload is sampled only at grant. Later changes to `req_*` and deassertion of `req` during the transaction are ignored, and the transaction always completes.
- Address or data NACKs are invisible to this block: the master returns to idle via STOP, which completes as `err`=0.
- A requester still holding `req` after `done` re-enters arbitration. It has lowest priority that round, so no requester can starve another.
- `busy` is 1 in LAUNCH, BUSY and DRAIN.

## Timing
- Grant latency: `req` sampled at edge N (IDLE, `m_ready`=1) → `gnt`, `m_enable` and `m_*` high after edge N.
- `m_ready` falls on the master's first divided-clock edge, typically within 4 `clk` cycles of `m_enable`.
- `done` is asserted for exactly one cycle, on the cycle after `m_ready` is sampled high in BUSY. `gnt` clears on the same edge.
- Back-to-back: the next grant comes no earlier than one cycle after `done`, and `ptr` has already advanced.
- Simultaneous requests at one edge: the lowest index at or after `ptr` wins.
- `rst` asserted mid-transaction clears all outputs immediately, including `m_enable`. The master shares `rst`, so it also returns to idle.

## Test plan
- Single write: `req[0]`, addr 0x50, wdata 0xA5, rw 0 → `gnt`=0001, the master drives address byte 0xA0 and data 0xA5 with the bench slave ACKing, then `done[0]` for 1 cycle with `err`=0 and `rdata` unchanged.
- Single read: `req[2]`, addr 0x3C, rw 1, slave returns 0x5A → `done[2]`, `rdata`=0x5A.
- Fairness: `req`=1111 held continuously → grants are 0,1,2,3,0 in order. Each `gnt` is one-hot and not reasserted before the previous `done`.
- Timeout: tie `m_ready`=1 constantly with TIMEOUT=15 → `m_enable` drops after 15 cycles in LAUNCH, `done[w]` and `err`=1, return to IDLE. Hold `m_ready`=0 in BUSY → `err`=1, then DRAIN until `m_ready`=1.
- Payload stability: change `req_wdata[7:0]` from 0x11 to 0x22 after the grant → the bus still carries 0x11.
- Reset mid-op: assert `rst` during BUSY → all outputs 0 and `busy`=0 within the same cycle. After release, `req[1]` is granted (`ptr`=0 search finds bit 1).
